mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer (HI/LO unit) beside the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and exposes busy for pipeline stall.
- Writes HI/LO registers read by MFHI/MFLO.
- Replaces a combinational multiply/divide path that would otherwise set the critical path.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_step.sv | 32 +++
 rtl/mdu_sequencer.sv | 135 +++++++++++++
 tb/tb_mdu_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide (HI/LO) sequencer:
// operation encoding and FSM state encoding.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative multiply/divide datapath.
// Multiply: shift-add on {upper(W+1), lower(W)}; divide: restoring step on
// {remainder(W+1), quotient(W)}. Operands are magnitudes (unsigned).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] diff;

  // Single combinational iteration; the MSB of diff is the trial-subtract borrow.
  always_comb begin
    sum  = {acc_in[2*WIDTH], acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shl  = {acc_in[2*WIDTH-1:0], 1'b0};
    diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, opnd};
    if (is_div) begin
      if (!diff[WIDTH+1]) acc_out = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
      else                acc_out = shl;
    end else if (acc_in[0]) begin
      acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
    end else begin
      acc_out = {2'b00, acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing HI/LO, one bit per cycle.
// Optional macro MDU_ABORT_EN adds an abort input that cancels a running
// operation without touching HI/LO.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc, acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res, neg_rem;

  logic               div_op, signed_op, div0, sgn1, sgn2, abort_hit;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem, fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? -x : x;
  endfunction

  // Operand decode, magnitudes and final sign correction of the raw result.
  always_comb begin
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div0      = div_op && (oprd2 == '0);
    sgn1      = signed_op && oprd1[WIDTH-1];
    sgn2      = signed_op && oprd2[WIDTH-1];
    abs1      = mag(oprd1, sgn1);
    abs2      = mag(oprd2, sgn2);
    prod      = acc[2*WIDTH-1:0];
    prod_fix  = neg_res ? -prod : prod;
    quot      = acc[WIDTH-1:0];
    rem       = acc[2*WIDTH-1:WIDTH];
    fix_hi    = is_div ? mag(rem, neg_rem) : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo    = is_div ? mag(quot, neg_res) : prod_fix[WIDTH-1:0];
`ifdef MDU_ABORT_EN
    abort_hit = abort && (state != IDLE);
`else
    abort_hit = 1'b0;
`endif
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_step)
  );

  // Next-state logic; abort (when built in) returns to IDLE from RUN/FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !div0) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counter, done/div_by_zero pulses and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          if (div0) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            hi          <= oprd1;
            lo          <= '1;
          end
        end
        RUN:  cnt <= cnt + CNT_W'(1);
        FIX:  if (!abort_hit) begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: load magnitudes at start, one step per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div  <= div_op;
      neg_res <= sgn1 ^ sgn2;
      neg_rem <= sgn1;
      acc     <= {{(WIDTH+1){1'b0}}, (div_op ? abs1 : abs2)};
      opnd    <= div_op ? abs2 : abs1;
    end else if (state == RUN) begin
      acc <= acc_step;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: a cycle-level reference model built
// from plain 64-bit arithmetic plus a fixed latency, compared every cycle,
// and literal expectations for the directed cases.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] oprd1, oprd2;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
`ifdef MDU_ABORT_EN
  logic        abort = 1'b0;
`endif

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef MDU_ABORT_EN
    .abort       (abort),
`endif
    .op          (op),
    .oprd1       (oprd1),
    .oprd2       (oprd2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic.
  function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rh, output logic [31:0] rl);
    logic signed [63:0] sa, sb, r;
    logic [63:0] ua, ub, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: begin r = sa * sb; rh = r[63:32]; rl = r[31:0]; end
      2'b01: begin ur = ua * ub; rh = ur[63:32]; rl = ur[31:0]; end
      2'b10: begin r = sa / sb; rl = r[31:0]; r = sa % sb; rh = r[31:0]; end
      default: begin ur = ua / ub; rl = ur[31:0]; ur = ua % ub; rh = ur[31:0]; end
    endcase
  endfunction

  // Reference model: an accepted op keeps the unit busy for WIDTH+1 cycles,
  // then publishes its result with a one-cycle done pulse.
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    m_dbz  = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_cnt   = 0;
      m_hi    = '0;
      m_lo    = '0;
    end
`ifdef MDU_ABORT_EN
    else if (abort && m_cnt > 0) m_cnt = 0;
`endif
    else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_hi   = p_hi;
        m_lo   = p_lo;
      end
    end else if (start) begin
      if (op[1] && oprd2 == 32'd0) begin
        m_done = 1'b1;
        m_dbz  = 1'b1;
        m_hi   = oprd1;
        m_lo   = 32'hFFFF_FFFF;
      end else begin
        calc(op, oprd1, oprd2, p_hi, p_lo);
        m_cnt = 33;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; oprd1 = a; oprd2 = b;
    @(negedge clk);
    start = 1'b0; op = ~o; oprd1 = ~a; oprd2 = ~b;
  endtask

  task automatic wait_done(output int bc, output int lat);
    bc = 0; lat = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int bc, lat;
    launch(o, a, b);
    wait_done(bc, lat);
    chk({name, ".hi"}, hi, eh);
    chk({name, ".lo"}, lo, el);
    chk({name, ".busy_cycles"}, bc, (o[1] && b == 0) ? 32'd0 : 32'd33);
    chk({name, ".latency"}, lat, (o[1] && b == 0) ? 32'd0 : 32'd33);
  endtask

  initial begin
    int bc, lat, nd;
    rst = 1'b1; start = 1'b0; op = 2'b00; oprd1 = '0; oprd2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Back-to-back: a start mid-RUN is dropped, a start in the done cycle is taken.
    launch(2'b01, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    launch(2'b11, 32'd50, 32'd3);
    wait_done(bc, lat);
    chk("b2b_first.lo", lo, 32'd42);
    chk("b2b_first.hi", hi, 32'd0);
    launch(2'b10, 32'hFFFF_FF9C, 32'd9);
    chk("b2b_gap.busy", {31'd0, busy}, 32'd1);
    wait_done(bc, lat);
    chk("b2b_second.lo", lo, 32'hFFFF_FFF5);
    chk("b2b_second.hi", hi, 32'hFFFF_FFFF);

    // Reset in the middle of a multiply discards it.
    launch(2'b00, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.hi", hi, 32'd0);
    chk("rst_mid.lo", lo, 32'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_mid.no_done", nd, 32'd0);

`ifdef MDU_ABORT_EN
    run_op("pre_abort", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15);
    launch(2'b01, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.hi", hi, 32'd0);
    chk("abort.lo", lo, 32'd15);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
